// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared encodings and instruction classifier for the multi-cycle MIPS controller
package multicycle_controller_pkg;
  typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_MULT, I_DIV, I_MFHI, I_MFLO, I_BAD
  } inst_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_LUI = 6'h0F, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_JR = 6'h08, FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV = 6'h1A, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
  localparam logic [2:0] NPC_PC4 = 3'b000, NPC_BEQ = 3'b001, NPC_JAL = 3'b010, NPC_JR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010, ALU_LUI = 3'b011;
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC4 = 2'b10, WD_HILO = 2'b11;
  localparam logic [1:0] MDU_MULT = 2'b00, MDU_DIV = 2'b01, MDU_MFHI = 2'b10, MDU_MFLO = 2'b11;
  function automatic inst_t decode_instr(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:
        case (fn)
          FN_ADD:  return I_ADD;
          FN_SUB:  return I_SUB;
          FN_JR:   return I_JR;
          FN_MULT: return I_MULT;
          FN_DIV:  return I_DIV;
          FN_MFHI: return I_MFHI;
          FN_MFLO: return I_MFLO;
          default: return I_BAD;
        endcase
      OP_ORI:  return I_ORI;
      OP_LW:   return I_LW;
      OP_SW:   return I_SW;
      OP_BEQ:  return I_BEQ;
      OP_LUI:  return I_LUI;
      OP_JAL:  return I_JAL;
      default: return I_BAD;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_controller_mdu_tracker.sv
// multicycle_controller_mdu_tracker: background countdown of outstanding mult/div latency
module multicycle_controller_mdu_tracker #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_busy
);
  logic [CNT_W-1:0] r_cnt;
  assign o_busy = |r_cnt;
  always_ff @(posedge clk)
    if (!reset) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : (o_busy ? r_cnt - 1'b1 : r_cnt);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake and MDU stall tracking
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic [2:0]  opNPC,
  output logic [2:0]  opALU,
  output logic        ALUsrc,
  output logic        opEXT,
  output logic        NumRead,
  output logic        NumWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        mdu_start,
  output logic [1:0]  mdu_op,
  output logic        illegal,
  output logic [2:0]  state
);
  localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_LAT);
  state_t           r_state, w_next;
  inst_t            w_inst;
  logic             w_busy, w_mdu, w_unused;
  logic [CNT_W-1:0] w_load_val;
  assign w_inst     = decode_instr(Instr[31:26], Instr[5:0]);
  assign w_mdu      = w_inst inside {I_MULT, I_DIV, I_MFHI, I_MFLO};
  assign w_load_val = (w_inst == I_DIV) ? L_DIV : L_MULT;
  assign w_unused   = ^Instr[25:6];
  assign state      = reset ? r_state : 3'd0;
  multicycle_controller_mdu_tracker #(.CNT_W(CNT_W)) u_mdu_tracker (
    .clk(clk), .reset(reset), .i_load(mdu_start), .i_val(w_load_val), .o_busy(w_busy)
  );
  always_ff @(posedge clk)
    if (!reset) r_state <= S_FETCH;
    else r_state <= w_next;
  // every strobe stays low while reset is held, whatever state is latched
  always_comb begin
    w_next = r_state;
    PCWrite = 1'b0; IRWrite = 1'b0; opNPC = NPC_PC4; opALU = ALU_ADD;
    ALUsrc = 1'b0; opEXT = 1'b0; NumRead = 1'b0; NumWrite = 1'b0;
    RegWrite = 1'b0; RegDst = DST_RT; WDSel = WD_ALU;
    mdu_start = 1'b0; mdu_op = MDU_MULT; illegal = 1'b0;
    if (reset)
      case (r_state)
        S_FETCH: begin
          IRWrite = 1'b1; PCWrite = 1'b1; w_next = S_DECODE;
        end
        S_DECODE: begin
          illegal = w_inst == I_BAD;
          w_next = (w_inst == I_BAD) ? S_FETCH : (w_mdu && w_busy) ? S_DECODE : S_EXEC;
        end
        S_EXEC: begin
          w_next = S_FETCH;
          case (w_inst)
            I_ADD, I_SUB: begin
              opALU = (w_inst == I_SUB) ? ALU_SUB : ALU_ADD; w_next = S_WB;
            end
            I_ORI: begin opALU = ALU_OR; ALUsrc = 1'b1; w_next = S_WB; end
            I_LUI: begin opALU = ALU_LUI; ALUsrc = 1'b1; w_next = S_WB; end
            I_LW, I_SW: begin ALUsrc = 1'b1; opEXT = 1'b1; w_next = S_MEM; end
            I_BEQ: begin opALU = ALU_SUB; opEXT = 1'b1; opNPC = NPC_BEQ; PCWrite = Zero; end
            I_JAL: begin
              opNPC = NPC_JAL; PCWrite = 1'b1; RegWrite = 1'b1; RegDst = DST_RA; WDSel = WD_PC4;
            end
            I_JR: begin opNPC = NPC_JR; PCWrite = 1'b1; end
            I_MULT, I_DIV: begin
              mdu_start = 1'b1; mdu_op = (w_inst == I_DIV) ? MDU_DIV : MDU_MULT;
            end
            I_MFHI, I_MFLO: w_next = S_WB;
            default: w_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          NumRead = w_inst == I_LW;
          NumWrite = w_inst == I_SW;
          w_next = !mem_ready ? S_MEM : (w_inst == I_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst = (w_inst inside {I_ORI, I_LUI, I_LW}) ? DST_RT : DST_RD;
          WDSel = (w_inst == I_LW) ? WD_MEM : (w_inst inside {I_MFHI, I_MFLO}) ? WD_HILO : WD_ALU;
          mdu_op = (w_inst == I_MFHI) ? MDU_MFHI : (w_inst == I_MFLO) ? MDU_MFLO : MDU_MULT;
          w_next = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle decode controller for the MIPS datapath.
- FSM sequences FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath strobes.
- Adds a memory ready handshake and a non-blocking multiply/divide unit (MDU) tracker with parametrised latencies.
- Sits between the IR/ALU-flag outputs and every datapath enable and mux select.

Parameters:
MULT_LAT, 5, cycles from mdu_start until HI/LO are valid for mult (must be at least 1)
DIV_LAT, 10, cycles from mdu_start until HI/LO are valid for div (must be at least 1)
CNT_W, 4, MDU counter width; 2^CNT_W must exceed max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low (0 = reset)
Instr  in  32  IR contents, valid from DECODE onward
Zero  in  1  ALU equality flag, valid in EXEC
mem_ready  in  1  data memory completes the access this cycle
PCWrite  out  1  PC load enable
IRWrite  out  1  IR load enable
opNPC  out  3  000 PC+4, 001 beq, 010 jal, 011 jr
opALU  out  3  000 add, 001 sub, 010 or, 011 lui
ALUsrc  out  1  1 = extended immediate as ALU B operand
opEXT  out  1  1 = sign extend, 0 = zero extend
NumRead  out  1  data memory read strobe
NumWrite  out  1  data memory write strobe
RegWrite  out  1  GRF write enable
RegDst  out  2  00 rt, 01 rd, 10 $31
WDSel  out  2  00 ALU, 01 memory, 10 PC+4, 11 HI/LO
mdu_start  out  1  one-cycle MDU launch pulse
mdu_op  out  2  00 mult, 01 div, 10 mfhi, 11 mflo
illegal  out  1  one-cycle pulse on an unsupported instruction
state  out  3  current FSM state, for debug

Behaviour:
- Supported instructions: add, sub, ori, lw, sw, beq, lui, jal, jr, mult (funct 0x18), div (0x1A), mfhi (0x10), mflo (0x12).
- Outputs are Moore-style, decoded from the state and Instr.
- While reset=0, all outputs are 0 and at the next edge state becomes FETCH and the MDU counter becomes 0.
- Reset asserted in any state, including MEM waits or an active MDU count, aborts the current operation.

FETCH:
- IRWrite=1, PCWrite=1, opNPC=000.
- Goes to DECODE.

DECODE:
- If the opcode/funct is unsupported: pulse illegal and go to FETCH; the instruction acts as a nop.
- If Instr is mult, div, mfhi or mflo and the MDU counter is non-zero: stay in DECODE (stall).
- Otherwise go to EXEC.

EXEC:
- R-type add/sub: opALU 000/001, ALUsrc=0, go to WB.
- ori: opALU 010, ALUsrc=1, opEXT=0, go to WB.
- lui: opALU 011, ALUsrc=1, go to WB.
- lw/sw: opALU 000, ALUsrc=1, opEXT=1, go to MEM.
- beq: opALU 001, opEXT=1, opNPC=001, PCWrite=Zero, go to FETCH.
- jal: opNPC=010, PCWrite=1, RegWrite=1, RegDst=10, WDSel=10, go to FETCH.
- jr: opNPC=011, PCWrite=1, go to FETCH.
- mult/div: mdu_start=1, mdu_op 00/01, counter loads MULT_LAT/DIV_LAT, go to FETCH (non-blocking).
- mfhi/mflo: go to WB.

MEM:
- NumRead (lw) or NumWrite (sw) is held high until mem_ready=1.
- On mem_ready: lw goes to WB, sw goes to FETCH.
- mem_ready sampled in any other state is ignored.

WB:
- RegWrite=1.
- RegDst: 01 for R-type, 00 for ori/lui/lw.
- WDSel: 00 for ALU results, 01 for lw, 11 for mfhi/mflo (mdu_op 10/11).
- Goes to FETCH.

MDU counter:
- Decrements by 1 per cycle while non-zero; saturates at 0.
- A load takes priority over the decrement in the same cycle.
- Counts in the background independent of the FSM.

Cycle counts: beq/j-class 3; ALU and mfhi/mflo 4; sw 4+waits; lw 5+waits; mult/div 3 plus any later stall.

Decomposition:
- Shared package: opcode/funct constants; state encodings (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4); opNPC, opALU, RegDst, WDSel and mdu_op encodings.
- One sub-module, mdu_tracker: the counter, load/decrement logic, and a busy output.

Test Plan:
- Reset held 3 cycles with Instr=0x00221820 -> all outputs 0, state=0; first cycle after release IRWrite=PCWrite=1.
- add 0x00221820 -> EXEC opALU=000, ALUsrc=0; WB RegWrite=1, RegDst=01, WDSel=00; next FETCH 4 cycles after the first FETCH.
- lw 0x8C220004 with mem_ready low 2 cycles -> NumRead=1 for 3 MEM cycles, then WB RegDst=00, WDSel=01; 7 cycles total; sw variant returns to FETCH with no WB.
- beq with Zero=1 then Zero=0 -> EXEC opNPC=001, PCWrite=1 then 0; both return to FETCH.
- mult 0x00220018 (MULT_LAT=5) followed by mflo 0x00001812 -> mdu_start pulse in EXEC; mflo stalls in DECODE until counter=0; WB WDSel=11, mdu_op=11, RegDst=01.
- Opcode 0x3F -> illegal=1 for one cycle in DECODE, then FETCH. Separately, reset=0 during a MEM wait -> FETCH with NumRead=0 and counter cleared.
